ifetch_q: RTL

Parametrised, decoupled instruction-fetch stage with a prefetch queue between instruction memory and ID. It replaces the single-entry IF/ID path with a DEPTH-entry queue, a req/gnt/rvalid memory interface with multiple in-flight reads, ID back-pressure (stall) and branch-redirect flush from MEM. It sits between the PC redirect path from MEM and the ID stage inputs `ID_ir`/`ID_npc`.

---
 rtl/ifetch_q.sv | 107 ++++++++++
 1 files changed

// File: rtl/ifetch_q.sv
// ifetch_q: decoupled instruction fetch with a DEPTH-entry prefetch queue, in-order multi-outstanding
// memory reads, ID stall and MEM redirect flush. Define IFETCH_Q_PERF_EN to add perf_fetched/perf_flushed.
module ifetch_q #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int DEPTH = 4,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] MEM_bpc,
   input  logic          MEM_PCSrc,
   input  logic          ID_stall,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_gnt,
   input  logic          imem_rvalid,
   input  logic [DW-1:0] imem_rdata,
   output logic          ID_valid,
   output logic [DW-1:0] ID_ir,
   output logic [AW-1:0] ID_npc
`ifdef IFETCH_Q_PERF_EN
   ,
   output logic [31:0]   perf_fetched,
   output logic [31:0]   perf_flushed
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] LIM = (CW+1)'(DEPTH);
   logic [AW-1:0] pc_q, pc_d, rpc_q, rpc_d, tgt;
   logic [CW-1:0] count_q, count_d, outst_q, outst_d;
   logic [15:0]   drop_q, drop_d;
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic          run_q;
   logic [DW-1:0] ir_q [DEPTH];
   logic [AW-1:0] npc_q [DEPTH];
   logic          fire, rv_drop, rv_take, rv_any, pop;

   // rpc_q is the address of the oldest live (non-dropped) outstanding request; responses arrive in order
   assign tgt       = MEM_bpc & ~AW'(3);
   assign imem_req  = run_q && !MEM_PCSrc && (({1'b0, count_q} + {1'b0, outst_q}) < LIM);
   assign imem_addr = pc_q;
   assign ID_valid  = count_q != '0;
   assign ID_ir     = ID_valid ? ir_q[head_q] : '0;
   assign ID_npc    = ID_valid ? npc_q[head_q] : '0;
   assign fire      = imem_req && imem_gnt;
   assign rv_drop   = imem_rvalid && drop_q != '0;
   assign rv_take   = imem_rvalid && drop_q == '0 && outst_q != '0;
   assign rv_any    = rv_drop || rv_take;
   assign pop       = ID_valid && !ID_stall;

   // next state: a redirect overrides everything and turns all in-flight reads into drops
   always_comb begin
      pc_d    = MEM_PCSrc ? tgt : pc_q + (fire ? AW'(4) : '0);
      rpc_d   = MEM_PCSrc ? tgt : rpc_q + (rv_take ? AW'(4) : '0);
      count_d = MEM_PCSrc ? '0 : count_q + CW'(rv_take) - CW'(pop);
      outst_d = MEM_PCSrc ? '0 : outst_q + CW'(fire) - CW'(rv_take);
      drop_d  = MEM_PCSrc ? drop_q + 16'(outst_q) - 16'(rv_any) : drop_q - 16'(rv_drop);
      head_d  = MEM_PCSrc ? '0 : head_q + PW'(pop);
      tail_d  = MEM_PCSrc ? '0 : tail_q + PW'(rv_take);
   end

   // control state registers; run_q delays the first request to the cycle after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         rpc_q   <= RESET_PC;
         count_q <= '0;
         outst_q <= '0;
         drop_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         run_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         rpc_q   <= rpc_d;
         count_q <= count_d;
         outst_q <= outst_d;
         drop_q  <= drop_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         run_q   <= 1'b1;
      end
   end

   // queue storage needs no reset: empty entries are masked at the ID outputs
   always_ff @(posedge clk) begin
      if (rv_take && !MEM_PCSrc) begin
         ir_q[tail_q]  <= imem_rdata;
         npc_q[tail_q] <= rpc_q + AW'(4);
      end
   end

`ifdef IFETCH_Q_PERF_EN
   // perf: instructions handed to ID, and entries/responses thrown away by redirects
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_flushed <= '0;
      end else begin
         perf_fetched <= perf_fetched + 32'(pop && !MEM_PCSrc);
         perf_flushed <= perf_flushed + (MEM_PCSrc ? 32'(count_q) + 32'(rv_any) : 32'(rv_drop));
      end
   end
`endif
endmodule
